// File: rtl/vector_issue_unit_if.sv
// Instruction handshake from the scalar core plus command/status bus to the vector unit.
interface vector_issue_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        vp_enable;
  logic        vp_start_op;
  logic [6:0]  vp_funct;
  logic [4:0]  vp_vs1;
  logic [4:0]  vp_vs2;
  logic [4:0]  vp_vr;
  logic [31:0] vp_vl;
  logic        vp_op_done;

  modport master (
    input  in_valid, in_instr, vp_op_done,
    output in_ready, vp_enable, vp_start_op, vp_funct, vp_vs1, vp_vs2, vp_vr, vp_vl
  );

  modport slave (
    output in_valid, in_instr, vp_op_done,
    input  in_ready, vp_enable, vp_start_op, vp_funct, vp_vs1, vp_vs2, vp_vr, vp_vl
  );
endinterface

// File: rtl/vector_issue_unit.sv
// Vector issue stage: buffers OP-V words, decodes them, handles SETVL locally and issues one op at a time.
// Optional macro ISSUE_STATS_EN adds saturating issued/illegal counters.
module vector_issue_unit #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned VECTOR_LENGTH = 4,
  parameter int unsigned VL_MAX        = 1023
) (
  input  logic                         clk,
  input  logic                         rst_n,
  vector_issue_unit_if.master          bus,
  input  logic                         issue_en,
  input  logic                         flush,
  output logic                         busy,
  output logic                         illegal,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]                  issued_count,
  output logic [7:0]                   illegal_count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [6:0]  OPC_V    = 7'b1010111;
  localparam logic [6:0]  F_VADD   = 7'h00;
  localparam logic [6:0]  F_VSUB   = 7'h01;
  localparam logic [6:0]  F_VMUL   = 7'h02;
  localparam logic [6:0]  F_VLE    = 7'h40;
  localparam logic [6:0]  F_VSE    = 7'h20;
  localparam logic [6:0]  F_SETVL  = 7'h7F;
  localparam logic [31:0] VL_MAX_W = 32'(VL_MAX);
  localparam logic [31:0] VL_RST   = 32'(VECTOR_LENGTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_d;

  logic [1:0]    state;
  logic [1:0]    state_d;

  logic          push;
  logic          pop;
  logic [31:0]   head;
  logic [6:0]    head_funct;
  logic          head_opc_ok;
  logic          head_vec;
  logic          head_setvl;
  logic [31:0]   req_vl;
  logic          unused_bits;

  logic          start_d;
  logic          busy_d;
  logic          illegal_d;
  logic          latch_fields;
  logic [31:0]   vl_d;

  // Storage only accepts a word when no flush is discarding the queue this cycle.
  assign push = bus.in_valid && bus.in_ready && !flush;

  // Decode of the FIFO head word.
  always_comb begin
    head        = mem[rd_ptr];
    head_funct  = head[31:25];
    head_opc_ok = (head[6:0] == OPC_V);
    head_vec    = head_opc_ok &&
                  ((head_funct == F_VADD) || (head_funct == F_VSUB) ||
                   (head_funct == F_VMUL) || (head_funct == F_VLE)  ||
                   (head_funct == F_VSE));
    head_setvl  = head_opc_ok && (head_funct == F_SETVL);
    req_vl      = 32'(head[24:15]);
  end

  assign unused_bits = ^head[14:12];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // FSM next state, pop decision and next values of the registered outputs.
  always_comb begin
    state_d      = state;
    pop          = 1'b0;
    start_d      = 1'b0;
    illegal_d    = 1'b0;
    latch_fields = 1'b0;
    vl_d         = bus.vp_vl;
    case (state)
      S_IDLE: begin
        if (issue_en && (fifo_count != '0) && !flush) begin
          pop = 1'b1;
          if (head_vec) begin
            state_d      = S_ISSUE;
            start_d      = 1'b1;
            latch_fields = 1'b1;
          end else if (head_setvl) begin
            vl_d = (req_vl > VL_MAX_W) ? VL_MAX_W : req_vl;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (bus.vp_op_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
  end

  // Flush wins over any same-cycle push or pop.
  always_comb begin
    count_d = fifo_count;
    if (flush) count_d = '0;
    else       count_d = fifo_count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fifo_count   <= '0;
      bus.in_ready <= 1'b1;
    end else begin
      fifo_count   <= count_d;
      bus.in_ready <= (count_d != CW'(FIFO_DEPTH));
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Payload storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_instr;
  end

  // Vector unit command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.vp_start_op <= 1'b0;
      bus.vp_enable   <= 1'b0;
      bus.vp_funct    <= '0;
      bus.vp_vs1      <= '0;
      bus.vp_vs2      <= '0;
      bus.vp_vr       <= '0;
      bus.vp_vl       <= VL_RST;
      busy            <= 1'b0;
      illegal         <= 1'b0;
    end else begin
      bus.vp_start_op <= start_d;
      bus.vp_enable   <= busy_d;
      bus.vp_vl       <= vl_d;
      busy            <= busy_d;
      illegal         <= illegal_d;
      if (latch_fields) begin
        bus.vp_funct <= head[31:25];
        bus.vp_vs1   <= head[19:15];
        bus.vp_vs2   <= head[24:20];
        bus.vp_vr    <= head[11:7];
      end
    end
  end

`ifdef ISSUE_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_count  <= '0;
      illegal_count <= '0;
    end else begin
      if (bus.vp_start_op && (issued_count != 16'hFFFF)) issued_count <= issued_count + 16'd1;
      if (illegal && (illegal_count != 8'hFF))           illegal_count <= illegal_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vector_issue_unit.sv
// Bench for vector_issue_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_vector_issue_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned VLEN  = 4;
  localparam int unsigned VLMAX = 500;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_en;
  logic       flush;
  logic       busy;
  logic       illegal;
  logic [2:0] fifo_count;
`ifdef ISSUE_STATS_EN
  logic [15:0] issued_count;
  logic [7:0]  illegal_count;
`endif

  vector_issue_unit_if bus();

  vector_issue_unit #(
    .FIFO_DEPTH    (DEPTH),
    .VECTOR_LENGTH (VLEN),
    .VL_MAX        (VLMAX)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.master),
    .issue_en      (issue_en),
    .flush         (flush),
    .busy          (busy),
    .illegal       (illegal),
    .fifo_count    (fifo_count)
`ifdef ISSUE_STATS_EN
    ,
    .issued_count  (issued_count),
    .illegal_count (illegal_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending words, one outstanding op, current vl.
  logic [31:0] m_q[$];
  bit          m_busy;
  bit          m_start;
  bit          m_ill;
  int unsigned m_vl;
  logic [6:0]  m_funct;
  logic [4:0]  m_vs1, m_vs2, m_vr;
  int unsigned m_issued;
  int unsigned m_illc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy   = 1'b0;
    m_start  = 1'b0;
    m_ill    = 1'b0;
    m_vl     = VLEN;
    m_funct  = '0;
    m_vs1    = '0;
    m_vs2    = '0;
    m_vr     = '0;
    m_issued = 0;
    m_illc   = 0;
  endtask

  // One clock of spec behaviour, using the inputs presented for that edge.
  task automatic model_step();
    int unsigned pre;
    int unsigned req;
    logic [31:0] w;
    logic [6:0]  f;
    bit          opc_ok;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_start && m_issued < 32'hFFFF) m_issued++;
    if (m_ill && m_illc < 32'hFF)       m_illc++;
    pre   = m_q.size();
    m_ill = 1'b0;
    if (m_start) begin
      m_start = 1'b0;
    end else if (m_busy) begin
      if (bus.vp_op_done) m_busy = 1'b0;
    end else if (issue_en && !flush && pre > 0) begin
      w      = m_q.pop_front();
      f      = w[31:25];
      opc_ok = (w[6:0] == 7'h57);
      if (opc_ok && (f == 7'h00 || f == 7'h01 || f == 7'h02 || f == 7'h40 || f == 7'h20)) begin
        m_busy  = 1'b1;
        m_start = 1'b1;
        m_funct = f;
        m_vs1   = w[19:15];
        m_vs2   = w[24:20];
        m_vr    = w[11:7];
      end else if (opc_ok && f == 7'h7F) begin
        req  = 32'(w[24:15]);
        m_vl = (req > VLMAX) ? VLMAX : req;
      end else begin
        m_ill = 1'b1;
      end
    end
    if (flush) m_q.delete();
    else if (bus.in_valid && pre < DEPTH) m_q.push_back(bus.in_instr);
  endtask

  task automatic check_all();
    check_eq("in_ready",   32'(bus.in_ready),    32'(m_q.size() < DEPTH));
    check_eq("fifo_count", 32'(fifo_count),      32'(m_q.size()));
    check_eq("busy",       32'(busy),            32'(m_busy));
    check_eq("vp_enable",  32'(bus.vp_enable),   32'(m_busy));
    check_eq("start_op",   32'(bus.vp_start_op), 32'(m_start));
    check_eq("illegal",    32'(illegal),         32'(m_ill));
    check_eq("vp_vl",      bus.vp_vl,            m_vl);
    check_eq("vp_funct",   32'(bus.vp_funct),    32'(m_funct));
    check_eq("vp_vs1",     32'(bus.vp_vs1),      32'(m_vs1));
    check_eq("vp_vs2",     32'(bus.vp_vs2),      32'(m_vs2));
    check_eq("vp_vr",      32'(bus.vp_vr),       32'(m_vr));
`ifdef ISSUE_STATS_EN
    check_eq("issued_count",  32'(issued_count),  m_issued);
    check_eq("illegal_count", 32'(illegal_count), m_illc);
`endif
  endtask

  task automatic cycle(input logic r, input logic v, input logic [31:0] w,
                       input logic ie, input logic fl, input logic dn);
    @(negedge clk);
    check_all();
    rst_n          = r;
    bus.in_valid   = v;
    bus.in_instr   = w;
    issue_en       = ie;
    flush          = fl;
    bus.vp_op_done = dn;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] w);
    cycle(1'b1, 1'b1, w, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic done();
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f, input logic [4:0] s2,
                                     input logic [4:0] s1, input logic [4:0] vr);
    return {f, s2, s1, 3'b000, vr, 7'h57};
  endfunction

  function automatic logic [31:0] setvl(input logic [9:0] v);
    return {7'h7F, v, 3'b000, 5'd0, 7'h57};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    logic [6:0]  fs [5];
    int          k;
    fs[0] = 7'h00; fs[1] = 7'h01; fs[2] = 7'h02; fs[3] = 7'h40; fs[4] = 7'h20;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k <= 4)      return {fs[k], r[24:7], 7'h57};
    else if (k <= 6) return setvl(r[9:0]);
    else if (k == 7) return {r[31:7], 7'h57};
    else if (k == 8) return {r[31:7], 7'h33};
    else             return r;
  endfunction

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.vp_op_done = 1'b0;
    issue_en       = 1'b0;
    flush          = 1'b0;
    model_reset();

    // Reset, then a single VADD through to completion.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(2);
    push(32'h0020_81D7);
    idle(5);
    done();
    idle(2);

    // SETVL ahead of a VSUB, then an over-range SETVL that clamps.
    push(setvl(10'd2));
    push(mk(7'h01, 5'd7, 5'd6, 5'd5));
    idle(4);
    done();
    idle(2);
    push(setvl(10'd1023));
    idle(3);
    #1 check_eq("vl_clamp", bus.vp_vl, 32'd500);

    // Fill the FIFO while the vector unit stalls, then drain it.
    for (int i = 0; i < 6; i++) push(mk(7'h02, 5'(i), 5'(i + 1), 5'(i + 2)));
    #1 check_eq("full_count", 32'(fifo_count), 32'd4);
    check_eq("full_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      done();
      idle(3);
    end

    // Bad opcode and bad funct are both dropped.
    push({7'h00, 18'h0_1234, 7'h33});
    push(mk(7'h05, 5'd1, 5'd2, 5'd3));
    idle(4);
`ifdef ISSUE_STATS_EN
    #1 check_eq("illegal_cnt2", 32'(illegal_count), 32'd2);
`endif

    // Flush while an op is waiting with three words queued.
    push(mk(7'h40, 5'd9, 5'd8, 5'd4));
    idle(3);
    for (int i = 0; i < 3; i++) push(mk(7'h00, 5'd1, 5'd1, 5'd1));
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    #1 check_eq("flush_count", 32'(fifo_count), 32'd0);
    idle(2);
    done();
    idle(5);

    // Reset during WAIT, late done ignored, issue_en low blocks the pop.
    push(mk(7'h20, 5'd3, 5'd2, 5'd1));
    idle(3);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    done();
    idle(2);
    cycle(1'b1, 1'b1, mk(7'h00, 5'd4, 5'd5, 5'd6), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 check_eq("hold_count", 32'(fifo_count), 32'd1);
    check_eq("hold_busy", 32'(busy), 32'd0);
    idle(4);
    done();
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 599) != 0,
            1'($urandom_range(0, 1)),
            rand_word(),
            $urandom_range(0, 7) != 0,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) == 0);
    end
    idle(2);
    @(negedge clk);
    check_all();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
